// File: rtl/v_loadu_param_if.sv
// Request handshake and bank-memory bus of the parametrised vector load unit.
// master = requester plus memory model, slave = the load unit.
interface v_loadu_param_if #(
    parameter int VLEN      = 128,
    parameter int NUM_BANKS = 4,
    parameter int ADDR_W    = 14,
    parameter int MAX_LMUL  = 4
);
    logic                        start;
    logic [3:0]                  v_lsu_op;
    logic [2:0]                  lmul;
    logic [31:0]                 base_addr;
    logic [31:0]                 stride;
    logic [NUM_BANKS*ADDR_W-1:0] data_addr;
    logic                        data_rd_en;
    logic [NUM_BANKS*32-1:0]     l_data_in;
    logic                        busy;
    logic                        l_done;
    logic [VLEN*MAX_LMUL-1:0]    l_data_out;

    modport master (
        output start, v_lsu_op, lmul, base_addr, stride, l_data_in,
        input  data_addr, data_rd_en, busy, l_done, l_data_out
    );

    modport slave (
        input  start, v_lsu_op, lmul, base_addr, stride, l_data_in,
        output data_addr, data_rd_en, busy, l_done, l_data_out
    );
endinterface

// File: rtl/v_loadu_param.sv
// Parametrised vector load unit: unit-stride and strided loads of 1..MAX_LMUL
// registers from NUM_BANKS word-interleaved synchronous banks (NUM_BANKS >= 2).
//
// state   | meaning
// S_IDLE  | waiting for a legal start
// S_ISSUE | one memory request per cycle
// S_DRAIN | last read data returning
// S_DONE  | result published, l_done high
module v_loadu_param #(
    parameter int VLEN      = 128,
    parameter int NUM_BANKS = 4,
    parameter int ADDR_W    = 14,
    parameter int MAX_LMUL  = 4
) (
    input  logic           clk,
    input  logic           nrst,
    v_loadu_param_if.slave bus
);
    localparam int BEAT_W    = NUM_BANKS * 32;
    localparam int BEAT_B    = NUM_BANKS * 4;
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int BANK_SH   = BANK_BITS + 2;
    localparam int OUT_W     = VLEN * MAX_LMUL;
    localparam int CNT_W     = $clog2(OUT_W / 8) + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t               state;
    logic [31:0]          run_addr;
    logic [31:0]          step;
    logic [CNT_W-1:0]     req_left;
    logic [CNT_W-1:0]     cap_idx;
    logic                 strided;
    logic [1:0]           sew;
    logic [BANK_BITS-1:0] sel_bank;
    logic [1:0]           sel_off;
    logic                 cap_v;
    logic [BANK_BITS-1:0] cap_bank;
    logic [1:0]           cap_off;
    logic [OUT_W-1:0]     acc;
    logic [OUT_W-1:0]     acc_next;
    logic [31:0]          word;

    logic                 op_legal;
    logic                 req_strided;
    logic [1:0]           sew_code;
    int                   nreg;
    int                   sew_bits;
    int                   n_total;

    always_comb begin
        op_legal    = (bus.v_lsu_op >= 4'd1) && (bus.v_lsu_op <= 4'd6);
        req_strided = (bus.v_lsu_op >= 4'd4);
        case (bus.v_lsu_op)
            4'd1, 4'd4: sew_code = 2'd0;
            4'd2, 4'd5: sew_code = 2'd1;
            default:    sew_code = 2'd2;
        endcase
        case (bus.lmul)
            3'b001:  nreg = 2;
            3'b010:  nreg = 4;
            3'b011:  nreg = 8;
            default: nreg = 1;
        endcase
        if (nreg > MAX_LMUL) nreg = MAX_LMUL;
        sew_bits = 8 << sew_code;
        n_total  = req_strided ? (nreg * VLEN / sew_bits) : (nreg * VLEN / BEAT_W);
    end

    // Shifting by the byte offset zero-fills, which gives misaligned elements their upper zero bytes.
    always_comb begin
        acc_next = acc;
        word     = bus.l_data_in[32'(cap_bank) * 32 +: 32] >> {cap_off, 3'b000};
        if (cap_v) begin
            if (!strided) begin
                acc_next[32'(cap_idx) * BEAT_W +: BEAT_W] = bus.l_data_in;
            end else begin
                case (sew)
                    2'd0:    acc_next[32'(cap_idx) * 8 +: 8]   = word[7:0];
                    2'd1:    acc_next[32'(cap_idx) * 16 +: 16] = word[15:0];
                    default: acc_next[32'(cap_idx) * 32 +: 32] = word;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state          <= S_IDLE;
            bus.busy       <= 1'b0;
            bus.l_done     <= 1'b0;
            bus.data_rd_en <= 1'b0;
            bus.data_addr  <= '0;
            bus.l_data_out <= '0;
            run_addr       <= '0;
            step           <= '0;
            req_left       <= '0;
            cap_idx        <= '0;
            strided        <= 1'b0;
            sew            <= '0;
            sel_bank       <= '0;
            sel_off        <= '0;
            cap_v          <= 1'b0;
            cap_bank       <= '0;
            cap_off        <= '0;
            acc            <= '0;
        end else begin
            bus.l_done <= 1'b0;
            cap_v      <= bus.data_rd_en;
            cap_bank   <= sel_bank;
            cap_off    <= sel_off;
            if (cap_v) begin
                acc     <= acc_next;
                cap_idx <= cap_idx + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (bus.start && op_legal) begin
                        // Request 0 goes out straight from the start inputs; unit-stride walks rows by one beat.
                        state          <= S_ISSUE;
                        bus.busy       <= 1'b1;
                        strided        <= req_strided;
                        sew            <= sew_code;
                        step           <= req_strided ? bus.stride : 32'(BEAT_B);
                        run_addr       <= bus.base_addr + (req_strided ? bus.stride : 32'(BEAT_B));
                        req_left       <= CNT_W'(n_total - 1);
                        bus.data_addr  <= {NUM_BANKS{bus.base_addr[BANK_SH +: ADDR_W]}};
                        bus.data_rd_en <= 1'b1;
                        sel_bank       <= bus.base_addr[2 +: BANK_BITS];
                        sel_off        <= bus.base_addr[1:0];
                        cap_idx        <= '0;
                        acc            <= '0;
                    end
                end
                S_ISSUE: begin
                    if (req_left != '0) begin
                        bus.data_addr <= {NUM_BANKS{run_addr[BANK_SH +: ADDR_W]}};
                        sel_bank      <= run_addr[2 +: BANK_BITS];
                        sel_off       <= run_addr[1:0];
                        run_addr      <= run_addr + step;
                        req_left      <= req_left - 1'b1;
                    end else begin
                        bus.data_rd_en <= 1'b0;
                        state          <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    bus.l_data_out <= acc_next;
                    bus.l_done     <= 1'b1;
                    state          <= S_DONE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/v_loadu_param.md
Name: v_loadu_param

Overview:
Parametrised vector load unit, successor to the fixed 128-bit/4-bank loader. It fetches one to MAX_LMUL vector registers from NUM_BANKS word-interleaved synchronous data-memory banks using a start/busy/done handshake. It supports unit-stride loads (VLE8/16/32) and strided loads (VLSE8/16/32) and packs the result into a register-group-wide output for the vector register file writeback.

Parameters:
VLEN, 128, bits per vector register; multiple of NUM_BANKS*32.
NUM_BANKS, 4, number of 32-bit memory banks read in parallel; power of two.
ADDR_W, 14, row-address width per bank.
MAX_LMUL, 4, largest register group supported (1, 2, 4 or 8).

Ports:
clk  in  1  clock, rising edge
nrst  in  1  asynchronous active-low reset
start  in  1  one-cycle request strobe
v_lsu_op  in  4  1=VLE8, 2=VLE16, 3=VLE32, 4=VLSE8, 5=VLSE16, 6=VLSE32
lmul  in  3  000=1 reg, 001=2, 010=4, 011=8, other=1
base_addr  in  32  byte address
stride  in  32  signed byte stride (strided ops only)
data_addr  out  NUM_BANKS*ADDR_W  per-bank row address, bank i in slice i
data_rd_en  out  1  memory read strobe
l_data_in  in  NUM_BANKS*32  bank read data, bank i in slice i; valid 1 cycle after address
busy  out  1  operation in progress
l_done  out  1  one-cycle completion pulse
l_data_out  out  VLEN*MAX_LMUL  packed register group, register 0 in LSBs

Behaviour:
- Reset (async, nrst=0): FSM=IDLE; busy=0, l_done=0, data_rd_en=0, data_addr=0, l_data_out=0; counters cleared. Reset mid-operation aborts the load with no l_done.
- Operation size is captured at start: nreg = decoded lmul, clamped to MAX_LMUL.
- Operation values are captured at start: op, base_addr and stride.
- start is accepted only in IDLE with op in 1..6. All other start events are ignored, with no busy and no l_done: start while busy, or an illegal op.
- FSM: IDLE -> ISSUE on accepted start; ISSUE -> DRAIN after the last request; DRAIN -> DONE after the last data capture; DONE -> IDLE unconditionally.
- busy=1 in ISSUE, DRAIN and DONE.
- l_done=1 only in DONE. l_data_out is updated at the DRAIN->DONE edge and holds until the next completion.
- Unit-stride requests:
  - N = nreg*VLEN/(NUM_BANKS*32) beats.
  - Beat k drives all banks with row = (base_addr >> log2(NUM_BANKS*4)) + k, truncated to ADDR_W. Low offset bits are ignored.
  - Beat k data fills l_data_out[k*NUM_BANKS*32 +: NUM_BANKS*32], with bank 0 lowest.
  - SEW does not affect packing.
- Strided requests:
  - SEW = 8/16/32 from op; E = nreg*VLEN/SEW elements, one per cycle.
  - Element k byte address a = base_addr + k*stride, computed mod 2^32 with signed stride. Zero and negative strides are legal.
  - Row = a >> log2(NUM_BANKS*4), bank = (a>>2) mod NUM_BANKS, byte offset = a[1:0].
  - The row address is driven on all banks.
  - The captured element is the selected bank word shifted right by 8*offset, truncated to SEW. It is written to l_data_out[k*SEW +: SEW].
  - SEW=16 with offset 3, or SEW=32 with nonzero offset, is misaligned; the element's lower bytes come from the shifted word and upper bytes are 0.
- Bank selection and offset for each element are pipelined one cycle to match the read latency.
- Timing, with the start cycle as cycle 0 and N = beats or E:
  - Request k is driven with data_rd_en=1 in cycle k+1.
  - The data for request k is captured at the end of cycle k+2.
  - l_done is asserted in cycle N+2.
  - The next start is accepted from cycle N+3.
- Bits of l_data_out above nreg*VLEN are 0 after every completion.
- data_rd_en=0 and data_addr holds its last value outside ISSUE.
- Offsets are computed incrementally (running address += stride), with no multiplier.

Test Plan:
- Reset: assert nrst mid-ISSUE of an lmul=010 VLE32 -> outputs 0 immediately; no l_done; busy=0.
- VLE32, lmul=000, base_addr=0x40, banks preloaded with row 4 = {0xD,0xC,0xB,0xA} -> data_addr all rows = 4 in cycle 1; l_done in cycle 3; l_data_out[127:0]=0x0000000D_0000000C_0000000B_0000000A; upper bits 0.
- VLE8, lmul=010 with MAX_LMUL=4, base_addr=0x100, memory word at byte address b equals b -> rows 0x10..0x13 in cycles 1..4; l_done in cycle 6; 512 bits match; a start in cycle 3 is ignored.
- VLSE32, lmul=000, base=0x10, stride=0x14 -> elements from bytes 0x10, 0x24, 0x38, 0x4C (banks 0, 1, 2, 3; rows 1, 2, 3, 4); l_done in cycle 6.
- VLSE8, stride=-1 (0xFFFFFFFF), base=0x0F, lmul=000 -> 16 elements from bytes 0x0F down to 0x00, so byte 0 of l_data_out = mem byte 0x0F; l_done in cycle 18.
- Stride 0, VLSE16 -> all 8 elements are equal; lmul=011 with MAX_LMUL=4 clamps to 4 registers; op=7 start -> ignored, busy stays 0.
